// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline register: load kinds and width defaults.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_W_DEFAULT  = 5;

    // Load kind carried alongside a MEM entry; unlisted codes behave as LW.
    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

endpackage

// File: rtl/load_align.sv
// Combinational little-endian lane select, sign/zero extension and alignment fault.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] raw_word,
    input  logic [1:0]        addr,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data,
    output logic              fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    load_type_e  kind;

    assign kind = load_type_e'(load_type);

    // Pick the addressed lanes, then extend according to the load kind.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch.
        data     = raw_word;
        fault    = 1'b0;
        byte_sel = raw_word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? raw_word[31:16] : raw_word[15:0];
        case (kind)
            LT_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LT_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            LT_LH: begin
                data  = {{(DATA_W-16){half_sel[15]}}, half_sel};
                fault = addr[0];
            end
            LT_LHU: begin
                data  = {{(DATA_W-16){1'b0}}, half_sel};
                fault = addr[0];
            end
            default: begin
                data  = raw_word;
                fault = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, fault gating, stall/flush and retire counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              In_Valid,
    input  logic              In_RegWrite,
    input  logic              In_MemtoReg,
    input  logic [2:0]        In_LoadType,
    input  logic [DATA_W-1:0] In_ALUResult,
    input  logic [DATA_W-1:0] In_MemData,
    input  logic [REG_W-1:0]  In_WriteReg,
    output logic              Valid,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic [DATA_W-1:0] ALUResult,
    output logic [DATA_W-1:0] DataMemory,
    output logic [REG_W-1:0]  WriteReg,
    output logic              Misaligned,
    output logic [DATA_W-1:0] FwdData,
    output logic [31:0]       RetiredCount
);

    logic [DATA_W-1:0] aligned_data;
    logic              align_fault;
    logic              fault;

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              misaligned_q, misaligned_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] data_memory_q, data_memory_d;
    logic [REG_W-1:0]  write_reg_q, write_reg_d;
    logic [31:0]       retired_count_q, retired_count_d;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .raw_word  (In_MemData),
        .addr      (In_ALUResult[1:0]),
        .load_type (In_LoadType),
        .data      (aligned_data),
        .fault     (align_fault)
    );

    // A misaligned access only matters when the entry actually reads memory.
    assign fault = align_fault & In_MemtoReg;

    // Next state: flush clears to a bubble, stall holds, otherwise capture the MEM entry.
    always_comb begin
        valid_d         = valid_q;
        reg_write_d     = reg_write_q;
        mem_to_reg_d    = mem_to_reg_q;
        misaligned_d    = misaligned_q;
        alu_result_d    = alu_result_q;
        data_memory_d   = data_memory_q;
        write_reg_d     = write_reg_q;
        retired_count_d = retired_count_q;
        if (Flush) begin
            valid_d       = 1'b0;
            reg_write_d   = 1'b0;
            mem_to_reg_d  = 1'b0;
            misaligned_d  = 1'b0;
            alu_result_d  = '0;
            data_memory_d = '0;
            write_reg_d   = '0;
        end else if (!Stall) begin
            valid_d         = In_Valid;
            reg_write_d     = In_RegWrite & In_Valid & ~fault;
            mem_to_reg_d    = In_MemtoReg;
            misaligned_d    = fault;
            alu_result_d    = In_ALUResult;
            data_memory_d   = fault ? '0 : aligned_data;
            write_reg_d     = In_WriteReg;
            retired_count_d = retired_count_q + 32'(In_Valid);
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: every flop, data fields included, is reset so outputs read 0 the instant Rst drops.
        if (!Rst) begin
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            misaligned_q    <= 1'b0;
            alu_result_q    <= '0;
            data_memory_q   <= '0;
            write_reg_q     <= '0;
            retired_count_q <= '0;
        end else begin
            // NOTE: non-blocking so all fields sample the same pre-edge _d values.
            valid_q         <= valid_d;
            reg_write_q     <= reg_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            misaligned_q    <= misaligned_d;
            alu_result_q    <= alu_result_d;
            data_memory_q   <= data_memory_d;
            write_reg_q     <= write_reg_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign Valid        = valid_q;
    assign RegWrite     = reg_write_q;
    assign MemtoReg     = mem_to_reg_q;
    assign Misaligned   = misaligned_q;
    assign ALUResult    = alu_result_q;
    assign DataMemory   = data_memory_q;
    assign WriteReg     = write_reg_q;
    assign RetiredCount = retired_count_q;
    assign FwdData      = mem_to_reg_q ? data_memory_q : alu_result_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected WB state is queued when stimulus is driven.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_RegWrite = 1'b0;
    logic        In_MemtoReg = 1'b0;
    logic [2:0]  In_LoadType = 3'b000;
    logic [31:0] In_ALUResult = '0;
    logic [31:0] In_MemData = '0;
    logic [4:0]  In_WriteReg = '0;
    logic        Valid, RegWrite, MemtoReg, Misaligned;
    logic [31:0] ALUResult, DataMemory, FwdData, RetiredCount;
    logic [4:0]  WriteReg;

    mem_wb_stage #(.DATA_W(32), .REG_W(5)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .Flush        (Flush),
        .In_Valid     (In_Valid),
        .In_RegWrite  (In_RegWrite),
        .In_MemtoReg  (In_MemtoReg),
        .In_LoadType  (In_LoadType),
        .In_ALUResult (In_ALUResult),
        .In_MemData   (In_MemData),
        .In_WriteReg  (In_WriteReg),
        .Valid        (Valid),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .ALUResult    (ALUResult),
        .DataMemory   (DataMemory),
        .WriteReg     (WriteReg),
        .Misaligned   (Misaligned),
        .FwdData      (FwdData),
        .RetiredCount (RetiredCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misaligned;
        logic [4:0]  write_reg;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] fwd;
        logic [31:0] count;
    } wb_t;

    typedef struct {
        logic        v;
        logic        rw;
        logic        m2r;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  wr;
    } stim_t;

    wb_t sb_q[$];
    wb_t last_exp = '0;
    wb_t obs, ex;
    int  checks = 0;
    int  failures = 0;

    function automatic wb_t observe();
        wb_t o;
        o.valid      = Valid;
        o.reg_write  = RegWrite;
        o.mem_to_reg = MemtoReg;
        o.misaligned = Misaligned;
        o.write_reg  = WriteReg;
        o.alu        = ALUResult;
        o.dm         = DataMemory;
        o.fwd        = FwdData;
        o.count      = RetiredCount;
        return o;
    endfunction

    // Reference load behaviour written with shifts and masks.
    function automatic logic [31:0] ref_align(input logic [31:0] word, input logic [1:0] addr,
                                              input logic [2:0] lt, output logic bad);
        logic [31:0] b, h;
        b = (word >> (32'(addr) * 8)) & 32'h0000_00FF;
        h = (word >> (32'(addr[1]) * 16)) & 32'h0000_FFFF;
        bad = 1'b0;
        case (lt)
            3'd1: ref_align = b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd2: ref_align = b;
            3'd3: begin ref_align = h[15] ? (h | 32'hFFFF_0000) : h; bad = addr[0]; end
            3'd4: begin ref_align = h; bad = addr[0]; end
            default: begin ref_align = word; bad = (addr != 2'b00); end
        endcase
    endfunction

    // Drive a normal load and queue the state the next edge must produce.
    task automatic push_load(input stim_t s);
        wb_t e;
        logic bad, mis;
        logic [31:0] data;
        Stall = 1'b0; Flush = 1'b0;
        In_Valid = s.v; In_RegWrite = s.rw; In_MemtoReg = s.m2r; In_LoadType = s.lt;
        In_ALUResult = s.alu; In_MemData = s.mem; In_WriteReg = s.wr;
        data = ref_align(s.mem, s.alu[1:0], s.lt, bad);
        mis = s.m2r & bad;
        e.valid      = s.v;
        e.reg_write  = s.rw & s.v & ~mis;
        e.mem_to_reg = s.m2r;
        e.misaligned = mis;
        e.write_reg  = s.wr;
        e.alu        = s.alu;
        e.dm         = mis ? 32'h0 : data;
        e.fwd        = s.m2r ? e.dm : s.alu;
        e.count      = last_exp.count + (s.v ? 32'd1 : 32'd0);
        sb_q.push_back(e);
        last_exp = e;
    endtask

    // Stall with scrambled inputs; the stage must hold everything.
    task automatic push_hold();
        Stall = 1'b1; Flush = 1'b0;
        In_Valid = 1'b1; In_RegWrite = 1'b1; In_MemtoReg = $urandom_range(0, 1);
        In_LoadType = 3'($urandom_range(0, 7)); In_ALUResult = $urandom;
        In_MemData = $urandom; In_WriteReg = 5'($urandom);
        sb_q.push_back(last_exp);
    endtask

    task automatic push_flush(input logic stall_too);
        wb_t e;
        Stall = stall_too; Flush = 1'b1;
        In_Valid = 1'b1; In_RegWrite = 1'b1; In_MemtoReg = 1'b1;
        In_ALUResult = 32'h1234_5678; In_MemData = 32'hCAFE_F00D; In_WriteReg = 5'd9;
        e = '0;
        e.count = last_exp.count;
        sb_q.push_back(e);
        last_exp = e;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        #2;
        sb_q.push_back('0);
        obs = observe(); ex = sb_q.pop_front();
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, ex);
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_load_kinds();
        stim_t q[$];
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_1003, 32'h80FF_1234, 5'd3});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd4, 32'h0000_2002, 32'h8001_0000, 5'd4});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd3, 32'h0000_2001, 32'h8001_0000, 5'd5});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_0001, 32'h80FF_1234, 5'd6});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd3, 32'h0000_0002, 32'h8001_0000, 5'd7});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd8});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd0, 32'h0000_0102, 32'hDEAD_BEEF, 5'd9});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd6, 32'h0000_0200, 32'h0BAD_F00D, 5'd10});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'd7, 32'h0000_0201, 32'h0BAD_F00D, 5'd11});
        q.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0303, 32'h7654_3210, 5'd12});
        q.push_back('{1'b0, 1'b1, 1'b1, 3'd1, 32'h0000_0400, 32'h0000_00F0, 5'd13});
        q.push_back('{1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_0402, 32'h00AB_0000, 5'd14});
        foreach (q[i]) begin
            @(negedge Clk);
            push_load(q[i]);
            @(posedge Clk); #1;
            obs = observe(); ex = sb_q.pop_front();
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL load_kind_%0d got=%h exp=%h", i, obs, ex);
            end
        end
    endtask

    task automatic test_random_loads();
        stim_t s;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            s.v = 1'($urandom); s.rw = 1'($urandom); s.m2r = 1'($urandom);
            s.lt = 3'($urandom_range(0, 7)); s.alu = $urandom; s.mem = $urandom;
            s.wr = 5'($urandom);
            push_load(s);
            @(posedge Clk); #1;
            obs = observe(); ex = sb_q.pop_front();
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL random_load_%0d got=%h exp=%h", i, obs, ex);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge Clk);
        push_load('{1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_0003, 32'h80FF_1234, 5'd17});
        @(posedge Clk); #1;
        void'(sb_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            push_hold();
            @(posedge Clk); #1;
            obs = observe(); ex = sb_q.pop_front();
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs, ex);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            push_load('{1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_5550, 32'h1111_2222, 5'd21});
            @(posedge Clk); #1;
            void'(sb_q.pop_front());
            @(negedge Clk);
            push_flush(i == 0);
            @(posedge Clk); #1;
            obs = observe(); ex = sb_q.pop_front();
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL flush_stall%0d got=%h exp=%h", 1 - i, obs, ex);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge Clk);
        Stall = 1'b1; Flush = 1'b0;
        dut.retired_count_q = 32'hFFFF_FFFF;
        last_exp.count = 32'hFFFF_FFFF;
        sb_q.push_back(last_exp);
        @(posedge Clk); #1;
        @(negedge Clk);
        push_load('{1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0777, 32'h0, 5'd1});
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                @(posedge Clk); #1;
            end
            obs = observe(); ex = sb_q.pop_front();
            checks++;
            if (obs.count !== ex.count) begin
                failures++;
                $display("FAIL counter_wrap_%0d got=%h exp=%h", i, obs.count, ex.count);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        push_load('{1'b1, 1'b1, 1'b1, 3'd0, 32'h0000_0010, 32'hA5A5_A5A5, 5'd30});
        @(posedge Clk); #1;
        void'(sb_q.pop_front());
        @(negedge Clk);
        push_hold();
        void'(sb_q.pop_front());
        Flush = 1'b1;
        @(posedge Clk); #2;
        Rst = 1'b0;
        #1;
        last_exp = '0;
        sb_q.push_back('0);
        obs = observe(); ex = sb_q.pop_front();
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs, ex);
        end
        @(negedge Clk);
        Rst = 1'b1;
        push_load('{1'b1, 1'b1, 1'b1, 3'd3, 32'h0000_0042, 32'hF00D_8000, 5'd2});
        @(posedge Clk); #1;
        obs = observe(); ex = sb_q.pop_front();
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL first_after_reset got=%h exp=%h", obs, ex);
        end
    endtask

    initial begin
        test_reset();
        test_load_kinds();
        test_random_loads();
        test_stall();
        test_flush();
        test_wrap();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
